// File: rtl/pipo_pkg.sv
// Shared constants and helpers for the PIPO pipeline.
// Holds the default WIDTH/DEPTH and the occupancy-width function.
package pipo_pkg;

    localparam int PIPO_WIDTH = 16;
    localparam int PIPO_DEPTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipo_stage.sv
// One pipeline stage: WIDTH data register plus valid bit.
// Ports: clk, clr_n (async clear), flush, i_load, i_valid, i_data -> o_valid, o_data.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Flush drops validity only; data is left as-is since
    // nothing downstream looks at it while the valid bit is low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipo_pipe.sv
// Bubble-collapsing PIPO pipeline of DEPTH stages with valid/ready handshake.
// Ports: clk, clr_n, flush, in_valid/in_ready/din, out_valid/out_ready/dout, occupancy.
module pipo_pipe
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_WIDTH,
    parameter int DEPTH = PIPO_DEPTH
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            din,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            dout,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_pv;
    logic [WIDTH-1:0] w_d  [DEPTH];
    logic [WIDTH-1:0] w_pd [DEPTH];
    logic             w_tail;
    logic [OCC_W-1:0] w_occ;

    // adv[i] = !v[i] || adv[i+1] unrolls to: out_ready, or some
    // stage from i to the end is empty. Computing it that way
    // keeps the chain free of self-referencing vector bits.
    always_comb begin
        w_tail = 1'b1;
        w_adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_tail   = w_tail & w_v[i];
            w_adv[i] = !w_tail || out_ready;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_v[i]);
        end
    end

    assign w_pv[0] = in_valid;
    assign w_pd[0] = din;

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_link
            assign w_pv[g] = w_v[g-1];
            assign w_pd[g] = w_d[g-1];
        end

        for (g = 0; g < DEPTH; g++) begin : g_stage
            pipo_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .clr_n   (clr_n),
                .flush   (flush),
                .i_load  (w_adv[g]),
                .i_valid (w_pv[g]),
                .i_data  (w_pd[g]),
                .o_valid (w_v[g]),
                .o_data  (w_d[g])
            );
        end
    endgenerate

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[DEPTH-1];
    assign dout      = w_d[DEPTH-1];
    assign occupancy = w_occ;

endmodule

// File: tb/tb_pipo_pipe.sv
// Self-checking bench for pipo_pipe (DEPTH=4/WIDTH=16 and DEPTH=1/WIDTH=8).
// Vector table, hand sequences and a per-DUT scoreboard queue.
module tb_pipo_pipe;

    logic        clk;
    logic        clr_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic [2:0]  occupancy;

    logic        flush2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  din2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  dout2;
    logic [0:0]  occ2;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb  [$];
    logic [7:0]  sb2 [$];

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        ir;
        int          occ;
        logic        ov;
        logic [15:0] dout;
        logic        cd;
    } vec_t;

    vec_t tbl [$];

    pipo_pipe #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .occupancy (occupancy)
    );

    pipo_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .din       (din2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .dout      (dout2),
        .occupancy (occ2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: transfers are decided by the values that are
    // stable at the falling edge before the next rising edge.
    always @(negedge clk) begin
        if (!clr_n) begin
            sb.delete();
            sb2.delete();
        end else begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_spurious actual=%0h required=none", dout);
                    end else begin
                        chk("sb_dout", 64'(dout), 64'(sb.pop_front()));
                    end
                end
                if (in_valid && in_ready) sb.push_back(din);
            end
            if (out_valid2 && out_ready2) begin
                if (sb2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb2_spurious actual=%0h required=none", dout2);
                end else begin
                    chk("sb2_dout", 64'(dout2), 64'(sb2.pop_front()));
                end
            end
            if (in_valid2 && in_ready2) sb2.push_back(din2);
        end
    end

    task automatic drive(input logic iv, input logic [15:0] d,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [7:0]  last;
        int          n_emit;

        clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0;
        out_ready = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0;
        din2 = '0; out_ready2 = 1'b0;

        tbl.push_back('{1'b1, 16'h00A0, 1'b0, 1'b1, 0, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h00A1, 1'b0, 1'b1, 1, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h00A2, 1'b0, 1'b1, 2, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h00A3, 1'b0, 1'b1, 3, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h00A4, 1'b0, 1'b0, 4, 1'b1, 16'h00A0, 1'b1});
        tbl.push_back('{1'b1, 16'h00A4, 1'b0, 1'b0, 4, 1'b1, 16'h00A0, 1'b1});
        tbl.push_back('{1'b1, 16'h00A4, 1'b1, 1'b1, 4, 1'b1, 16'h00A0, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 4, 1'b1, 16'h00A1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 4, 1'b1, 16'h00A1, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 3, 1'b1, 16'h00A2, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 2, 1'b1, 16'h00A3, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1, 1'b1, 16'h00A4, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h1111, 1'b0, 1'b1, 0, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b1, 16'h2222, 1'b0, 1'b1, 1, 1'b0, 16'h0,    1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 2, 1'b1, 16'h1111, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1, 1'b1, 16'h2222, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'h0,    1'b0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ov",   64'(out_valid), 64'd0);
        chk("rst_dout", 64'(dout),      64'd0);
        chk("rst_occ",  64'(occupancy), 64'd0);
        chk("rst_ir",   64'(in_ready),  64'd1);
        chk("rst_ov2",  64'(out_valid2), 64'd0);
        @(posedge clk);
        #2 clr_n = 1'b1;

        // Streaming: word accepted at edge 1 of the loop shows up
        // in cycle 4, then one word per cycle in order.
        for (int c = 0; c < 12; c++) begin
            drive(c < 8, (c < 8) ? 16'(c + 1) : 16'h0, 1'b1, 1'b0);
            chk($sformatf("str%0d_ir", c), 64'(in_ready), 64'd1);
            if (c == 3) chk("str_lat_ov", 64'(out_valid), 64'd0);
            if (c >= 4) begin
                chk($sformatf("str%0d_ov", c), 64'(out_valid), 64'd1);
                chk($sformatf("str%0d_dout", c), 64'(dout), 64'(c - 3));
            end
        end
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure / full / bubble collapse table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].din, tbl[i].ordy, 1'b0);
            chk($sformatf("vec%0d_ir", i),  64'(in_ready),  64'(tbl[i].ir));
            chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
            chk($sformatf("vec%0d_ov", i),  64'(out_valid), 64'(tbl[i].ov));
            if (tbl[i].cd) begin
                chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(tbl[i].dout));
            end
        end

        // Flush with three words held and a word offered
        drive(1'b1, 16'h00C1, 1'b0, 1'b0);
        drive(1'b1, 16'h00C2, 1'b0, 1'b0);
        drive(1'b1, 16'h00C3, 1'b0, 1'b0);
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("fl_occ_pre", 64'(occupancy), 64'd3);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_ov",  64'(out_valid), 64'd0);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("fl_drain%0d_ov", c), 64'(out_valid), 64'd0);
        end

        // Async reset between edges with two words in flight
        drive(1'b1, 16'h00D1, 1'b0, 1'b0);
        drive(1'b1, 16'h00D2, 1'b0, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        chk("ar_dout", 64'(dout),      64'd0);
        chk("ar_ov",   64'(out_valid), 64'd0);
        chk("ar_occ",  64'(occupancy), 64'd0);
        chk("ar_ir",   64'(in_ready),  64'd1);
        @(negedge clk);
        #2 clr_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 16'h5A5A, 1'b1, 1'b0);
            if (c == 3) chk("ar_lat_ov", 64'(out_valid), 64'd0);
            if (c == 4) begin
                chk("ar_out_ov",   64'(out_valid), 64'd1);
                chk("ar_out_dout", 64'(dout),      64'h5A5A);
            end
        end
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // DEPTH=1: in_valid held, out_ready alternating
        acc    = 1'b0;
        last   = '0;
        n_emit = 0;
        din2   = 8'h10;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (acc) din2 = din2 + 8'd1;
            in_valid2  = 1'b1;
            out_ready2 = c[0];
            @(negedge clk);
            if (acc) begin
                chk($sformatf("d1_%0d_ov", c),   64'(out_valid2), 64'd1);
                chk($sformatf("d1_%0d_dout", c), 64'(dout2),      64'(last));
            end
            chk($sformatf("d1_%0d_ir", c), 64'(in_ready2),
                64'(!out_valid2 || out_ready2));
            acc = in_ready2;
            if (acc) last = din2;
            if (out_valid2 && out_ready2) n_emit++;
        end
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        out_ready2 = 1'b0;
        chk("d1_emit_cnt", 64'(n_emit),     64'd10);
        chk("d1_sb_left",  64'(sb2.size()), 64'd1);
        chk("sb_left",     64'(sb.size()),  64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipo_pipe.md
PIPO_PIPE -- requirements
Module: pipo_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all stages, active-high.
REQ-006 in_valid  input  1  din is valid this cycle.
REQ-007 in_ready  output  1  stage 0 accepts data this cycle.
REQ-008 din  input  WIDTH  parallel input word.
REQ-009 out_valid  output  1  dout is valid; equals the valid bit of stage DEPTH-1.
REQ-010 out_ready  input  1  downstream accepts dout this cycle.
REQ-011 dout  output  WIDTH  parallel output word; equals the data of stage DEPTH-1.
REQ-012 occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-013 Each stage i SHALL hold one WIDTH-bit data register and one valid bit v[i].
REQ-014 Last stage: adv[DEPTH-1] = !v[DEPTH-1] || out_ready.
REQ-015 Other stages: adv[i] = !v[i] || adv[i+1]. This is bubble-collapsing: an empty stage always accepts.
REQ-016 in_ready SHALL equal adv[0]. It is combinational from out_ready and the v bits, and never depends on in_valid.
REQ-017 Stage 0 load: on a clock edge with adv[0]=1, v[0] <= in_valid. Data[0] <= din only when in_valid=1.
REQ-018 Stage i>0 load: on a clock edge with adv[i]=1, v[i] <= v[i-1] and data[i] <= data[i-1]. Data SHALL load only when v[i-1]=1.
REQ-019 A stage with adv[i]=0 SHALL hold its data and its valid bit.
REQ-020 Transfer rules: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-021 Latency: with no backpressure and an empty pipe, a word accepted at edge N SHALL appear on dout with out_valid=1 after edge N+DEPTH-1. That is DEPTH register stages, first-in first-out.
REQ-022 Throughput: with out_ready held at 1, the block SHALL accept one word per cycle indefinitely.
REQ-023 Ordering: words SHALL leave in acceptance order. No word SHALL be dropped or duplicated.
REQ-024 Full pipe (all v=1) with out_ready=0: in_ready=0 and all stages hold. dout SHALL remain stable until it is accepted.
REQ-025 Full pipe with out_ready=1: in_ready=1, so a simultaneous accept and emit is allowed and occupancy SHALL be unchanged.
REQ-026 occupancy SHALL equal the population count of v. It SHALL reach DEPTH when full and 0 when empty. It is registered-consistent with v, with no extra lag.
REQ-027 flush=1 at an edge: all v <= 0. Any input offered in that cycle SHALL be discarded. Data registers need not clear.
REQ-028 flush priority: flush SHALL have priority over every load and advance.
REQ-029 DEPTH=1: the block SHALL degenerate to a single PIPO register with handshake. in_ready = !v[0] || out_ready.

Reset
REQ-030 While clr_n=0: all v bits 0, all data registers 0, out_valid=0, dout=0, occupancy=0, independent of clk.
REQ-031 Reset deassertion: after clr_n rises, the first accepting edge SHALL behave as an empty pipe.
REQ-032 Reset mid-operation: all in-flight words SHALL be lost. in_ready SHALL be 1 while clr_n=0.

Structure
REQ-033 Package pipo_pkg SHALL hold the default WIDTH and DEPTH constants and a function computing the occupancy width.
REQ-034 One sub-module, pipo_stage (WIDTH data register plus valid bit, with load and async clear), SHALL be instantiated DEPTH times via generate.
REQ-035 The adv chain and the occupancy adder SHALL live in pipo_pipe.

Verification
REQ-036 Streaming: WIDTH=16, DEPTH=4, out_ready=1, din=0x0001..0x0008 on consecutive cycles. Required: 0x0001 on dout four edges after acceptance, then one word per cycle in order.
REQ-037 Backpressure and full: out_ready=0, push 0x00A0..0x00A3, then offer 0x00A4. Required: in_ready=0, occupancy=4, dout=0x00A0 stable. Then out_ready=1 for one cycle. Required: 0x00A0 emitted, 0x00A4 accepted the same edge, occupancy stays 4.
REQ-038 Bubble collapse: push 0x1111, idle 2 cycles, push 0x2222, out_ready=0 for 6 cycles. Required: both words packed in stages 3 and 2, occupancy=2, emitted in order once released.
REQ-039 Flush: pipe holding 3 words with in_valid=1, din=0xBEEF, and flush pulsed. Required: occupancy=0 and out_valid=0 next cycle, and 0xBEEF never appears.
REQ-040 Async reset: clr_n dropped between clock edges with 2 words in flight. Required: dout=0, out_valid=0, occupancy=0 immediately. After release, 0x5A5A emerges after DEPTH edges.
REQ-041 DEPTH=1, WIDTH=8: alternating out_ready with in_valid held at 1. Required: one-cycle latency, no loss, no duplication, with a scoreboard check.
